// File: rtl/int8_packer_if.sv
// Output word stream of int8_packer: packed word, byte count and last flag
// with a valid/ready handshake toward the output buffer writer.
interface int8_packer_if #(
    parameter int LANES = 4
);
    localparam int BW = $clog2(LANES + 1);

    logic [LANES*8-1:0] out_data;
    logic [BW-1:0]      out_bytes;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output out_data, out_bytes, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_bytes, out_last, out_valid,
        output out_ready
    );
endinterface

// File: rtl/int8_packer.sv
// Packs a stream of int8 results into LANES-byte words and queues them in a small FIFO.
// Define INT8_PACKER_RELU_EN to clamp negative bytes to zero before packing.
module int8_packer #(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     in_data,
    input  logic           in_valid,
    input  logic           flush,
    int8_packer_if.master  out,
    output logic           overflow,
    output logic           idle
);
    localparam int FW = $clog2(LANES);
    localparam int CW = $clog2(LANES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    logic [LANES-1:0][7:0] lanes;
    logic [LANES-1:0][7:0] word;
    logic [FW-1:0]         fill;
    logic [CW-1:0]         cnt_next;
    logic [7:0]            byte_in;
    logic                  close;

    logic [LANES*8-1:0]    mem_data  [FIFO_DEPTH];
    logic [CW-1:0]         mem_bytes [FIFO_DEPTH];
    logic                  mem_last  [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [OW-1:0]         occ;
    logic                  full;
    logic                  pop;
    logic                  wr_en;

`ifdef INT8_PACKER_RELU_EN
    assign byte_in = in_data[7] ? 8'h00 : in_data;
`else
    assign byte_in = in_data;
`endif

    // The closing word includes this cycle's byte, so it is built combinationally.
    always_comb begin
        word = lanes;
        if (in_valid)
            word[fill] = byte_in;
        cnt_next = CW'(fill) + CW'(in_valid);
        close    = (cnt_next == CW'(LANES)) || (flush && (cnt_next != '0));
    end

    assign full          = (occ == OW'(FIFO_DEPTH));
    assign out.out_valid = (occ != '0);
    assign pop           = out.out_valid && out.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_en         = close && (!full || pop);

    assign out.out_data  = mem_data[rd_ptr];
    assign out.out_bytes = mem_bytes[rd_ptr];
    assign out.out_last  = mem_last[rd_ptr];
    assign idle          = (fill == '0) && (occ == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            lanes    <= '0;
            fill     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i]  <= '0;
                mem_bytes[i] <= '0;
                mem_last[i]  <= 1'b0;
            end
        end else begin
            if (close) begin
                lanes <= '0;
                fill  <= '0;
            end else if (in_valid) begin
                lanes <= word;
                fill  <= fill + 1'b1;
            end

            if (wr_en) begin
                mem_data[wr_ptr]  <= word;
                mem_bytes[wr_ptr] <= cnt_next;
                mem_last[wr_ptr]  <= flush;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (close && !wr_en)
                overflow <= 1'b1;

            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({wr_en, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_int8_packer.sv
// Scoreboard bench for int8_packer: a byte-queue model predicts words, a monitor
// compares every presented FIFO head against the expected queue.
module tb_int8_packer;
    localparam int LANES = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bytes;
        logic        last;
    } word_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       flush;
    logic       overflow;
    logic       idle;

    int8_packer_if #(.LANES(LANES)) ifc ();

    int8_packer #(.LANES(LANES), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .flush    (flush),
        .out      (ifc.master),
        .overflow (overflow),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    word_t      exp_q[$];
    logic [7:0] cur[$];
    int         occ;
    bit         m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] relu(input logic [7:0] b);
`ifdef INT8_PACKER_RELU_EN
        return ($signed(b) < 0) ? 8'h00 : b;
`else
        return b;
`endif
    endfunction

    // Monitor: every presented head must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && ifc.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head: unexpected word %h, none expected", ifc.out_data);
            end else begin
                chk("head_data", ifc.out_data, exp_q[0].data);
                chk("head_bytes", 32'(ifc.out_bytes), 32'(exp_q[0].bytes));
                chk("head_last", 32'(ifc.out_last), 32'(exp_q[0].last));
                if (ifc.out_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; the model predicts the effect of the coming edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit f, input bit r);
        word_t w;
        bit    pop;
        chk("out_valid", 32'(ifc.out_valid), 32'(occ != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("idle", 32'(idle), 32'(cur.size() == 0 && occ == 0));
        in_valid = v;
        in_data = d;
        flush = f;
        ifc.out_ready = r;
        pop = (occ > 0) && r;
        if (v)
            cur.push_back(relu(d));
        if (cur.size() == LANES || (f && cur.size() > 0)) begin
            w.data = '0;
            foreach (cur[i])
                w.data[8*i +: 8] = cur[i];
            w.bytes = 3'(cur.size());
            w.last = f;
            if (occ < DEPTH || pop) begin
                exp_q.push_back(w);
                occ++;
            end else begin
                m_ovf = 1'b1;
            end
            cur.delete();
        end
        if (pop)
            occ--;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        in_data = '0;
        ifc.out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        cur.delete();
        occ = 0;
        m_ovf = 1'b0;
        chk("rst_data", ifc.out_data, 32'h0);
        chk("rst_bytes", 32'(ifc.out_bytes), 32'h0);
        chk("rst_last", 32'(ifc.out_last), 32'h0);
        chk("rst_valid", 32'(ifc.out_valid), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH + 4 && occ > 0; i++)
            cycle(0, 8'h00, 0, 1);
        chk("drain_occ", 32'(ifc.out_valid), 32'h0);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        occ = 0;
        m_ovf = 1'b0;
        do_reset();

        // Four consecutive bytes form one full word.
        cycle(1, 8'h01, 0, 1);
        cycle(1, 8'h02, 0, 1);
        cycle(1, 8'h03, 0, 1);
        cycle(1, 8'h04, 0, 1);
        chk("full_valid", 32'(ifc.out_valid), 32'h1);
        chk("full_data", ifc.out_data, 32'h04030201);
        chk("full_bytes", 32'(ifc.out_bytes), 32'd4);
        chk("full_last", 32'(ifc.out_last), 32'h0);
        cycle(0, 8'h00, 0, 1);
        chk("idle_after_pop", 32'(idle), 32'h1);

        // Partial flush, then a flush with nothing pending.
        cycle(1, 8'h7F, 0, 1);
        cycle(1, 8'h80, 0, 1);
        cycle(0, 8'h00, 1, 1);
        chk("part_data", ifc.out_data, relu(8'h7F) | (32'(relu(8'h80)) << 8));
        chk("part_bytes", 32'(ifc.out_bytes), 32'd2);
        chk("part_last", 32'(ifc.out_last), 32'h1);
        cycle(0, 8'h00, 1, 1);
        chk("flush_noop", 32'(ifc.out_valid), 32'h0);

        // Flush on the byte that completes a word.
        cycle(1, 8'h2A, 0, 1);
        cycle(1, 8'h3B, 0, 1);
        cycle(1, 8'h4C, 0, 1);
        cycle(1, 8'h11, 1, 1);
        chk("fl_full_data", ifc.out_data, 32'h114C3B2A);
        chk("fl_full_bytes", 32'(ifc.out_bytes), 32'd4);
        chk("fl_full_last", 32'(ifc.out_last), 32'h1);
        cycle(0, 8'h00, 0, 1);

        // Five words with the consumer stalled: the fifth is dropped.
        do_reset();
        for (int i = 0; i < 5 * LANES; i++)
            cycle(1, 8'($urandom), 0, 0);
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_sb_depth", 32'(exp_q.size()), 32'(DEPTH));
        drain();
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // Full FIFO accepts a closing word when a pop happens the same cycle.
        do_reset();
        for (int i = 0; i < DEPTH * LANES + LANES - 1; i++)
            cycle(1, 8'($urandom), 0, 0);
        cycle(1, 8'($urandom), 0, 1);
        cycle(0, 8'h00, 0, 0);
        chk("full_pop_no_ovf", 32'(overflow), 32'h0);
        drain();

        // Reset mid-word with queued words discards everything.
        do_reset();
        for (int i = 0; i < 2 * LANES + 3; i++)
            cycle(1, 8'($urandom), 0, 0);
        do_reset();
        cycle(1, 8'h05, 0, 1);
        cycle(1, 8'h06, 0, 1);
        cycle(1, 8'h07, 0, 1);
        cycle(1, 8'h08, 0, 1);
        chk("post_rst_data", ifc.out_data, 32'h08070605);
        cycle(0, 8'h00, 0, 1);

        // Sign handling of stored bytes.
        cycle(1, 8'hFF, 0, 1);
        cycle(1, 8'h10, 0, 1);
        cycle(1, 8'h80, 0, 1);
        cycle(1, 8'h7F, 0, 1);
`ifdef INT8_PACKER_RELU_EN
        chk("relu_data", ifc.out_data, 32'h7F001000);
`else
        chk("relu_data", ifc.out_data, 32'h7F8010FF);
`endif
        cycle(0, 8'h00, 0, 1);

        // Randomized traffic with occasional flushes and stalls.
        do_reset();
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 9) < 7), 8'($urandom),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6));
        cycle(0, 8'h00, 1, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/int8_packer.md
# int8_packer

Output-side packing stage directly downstream of the int32-to-int8 quantizer pipeline. Collects the quantizer's stream of signed int8 results (single-cycle valid pulses, no backpressure) into LANES-byte words, buffers completed words in a small FIFO, and presents them on a valid/ready interface toward the output buffer writer. Supports flushing a partial word at the end of a tile or row, and reports sticky overflow when the downstream consumer stalls too long.

## Interface
- LANES, 4: bytes per output word; power of two, 2..32.
- FIFO_DEPTH, 4: completed-word FIFO entries; power of two, 2..16.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- in_data  in  8  signed int8 from quantizer.
- in_valid  in  1  in_data is valid this cycle; always accepted, no ready.
- flush  in  1  close the current partial word after this cycle's input.
- out_data  out  LANES*8  packed word; byte k at bits [8k+7:8k].
- out_bytes  out  $clog2(LANES+1)  valid byte count of out_data, 1..LANES.
- out_last  out  1  word was closed by flush.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer takes the head when out_valid && out_ready.
- overflow  out  1  sticky: a completed word was dropped.
- idle  out  1  fill count 0 and FIFO empty.

## Operation
- Fill register: LANES bytes plus fill count `fill` (0..LANES-1). An accepted byte is written to lane `fill`, then `fill` increments.
- Word close: occurs on the cycle that accepts the byte bringing the total to LANES (out_bytes=LANES, out_last=0), or on a flush cycle with a nonzero resulting count.
- Flush semantics:
  - A byte accepted in the same cycle as flush is included first.
  - Unfilled lanes are zero-padded; out_bytes = byte count; out_last=1.
  - If flush coincides with the byte that completes a full word: one word is pushed, with out_bytes=LANES and out_last=1.
  - Flush with no pending bytes and no in_valid is a no-op.
- After a close, `fill` returns to 0 and lane registers are zeroed.
- FIFO:
  - Push on word close; pop when out_valid && out_ready.
  - Simultaneous push and pop is allowed at any occupancy, including full.
  - Push when full without a same-cycle pop: the word is dropped, FIFO contents are unchanged, and overflow is set. overflow stays high until reset.
- out_data, out_bytes, and out_last show the FIFO head. They are held stable while out_valid && !out_ready.
- Arithmetic: no arithmetic on data except optional ReLU (see Configuration). Bytes are stored as-is, in two's complement.

## Timing
- Reset values: out_data=0, out_bytes=0, out_last=0, out_valid=0, overflow=0, idle=1. Fill count, lane registers, and FIFO pointers are all cleared.
- Latency from the closing input cycle to out_valid=1 is 1 cycle when the FIFO was empty.
- Throughput: one byte per cycle sustained. out_ready=1 drains one word per cycle.
- Reset asserted mid-word or with a non-empty FIFO discards all data. Reset takes priority over in_valid, flush, and out_ready in the same cycle.
- idle deasserts the cycle after the first accepted byte. It reasserts the cycle after the last pop when fill=0.

## Configuration
- INT8_PACKER_RELU_EN:
  - Defined: each accepted byte with in_data < 0 is stored as 0x00 before packing, so -128 becomes 0 and 127 stays 127.
  - Undefined: bytes are stored unmodified.
  - Latency and handshake are identical in both builds.

## Test plan
- Default params, out_ready=1, bytes 0x01,0x02,0x03,0x04 on 4 consecutive cycles -> next cycle out_valid=1, out_data=0x04030201, out_bytes=4, out_last=0; idle=1 one cycle later.
- Bytes 0x7F,0x80, then flush alone -> out_data=0x0000807F, out_bytes=2, out_last=1. A second flush alone produces no word.
- Byte 0x11 with flush on the same cycle as the 4th byte of a word (0xAA,0xBB,0xCC,0x11) -> single word 0x11CCBBAA, out_bytes=4, out_last=1.
- out_ready=0, push 5 full words -> FIFO holds the first 4, overflow=1 after the 5th close. Raising out_ready then yields exactly words 1..4 in order, with overflow still 1.
- FIFO full with out_ready=1 on the same cycle a word closes -> no drop, overflow stays 0, occupancy stays 4.
- Reset after 3 bytes and 2 queued words -> all outputs return to reset values. A following 0x05,0x06,0x07,0x08 gives 0x08070605.
- ReLU build: bytes 0xFF,0x10,0x80,0x7F -> 0x7F001000; non-ReLU build gives 0x7F8010FF.
